// File: rtl/audio_fir_pkg.sv
// Shared types and arithmetic helpers for the audio FIR datapath.
//   fir_state_e : sequencing states of the decimating FIR.
//   acc_width   : accumulator width that cannot overflow for a TAPS-long sum.
//   round_sat   : round-half-up and saturate an accumulator to the sample width.
package audio_fir_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StDrain,
    StRound
  } fir_state_e;

  function automatic int unsigned acc_width(input int unsigned iw, input int unsigned cw,
                                            input int unsigned taps);
    return iw + cw + $clog2(taps);
  endfunction

  // Works on a 64-bit carrier so one helper serves every parameterisation; only the low
  // aw bits of acc are meaningful and are re-sign-extended here. Requires aw <= 62, cw >= 2.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int unsigned aw,
                                                   input int unsigned iw,
                                                   input int unsigned cw);
    logic signed [63:0] sext;
    logic signed [63:0] rounded;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sext    = (acc <<< (64 - aw)) >>> (64 - aw);
    rounded = (sext + (64'sd1 <<< (cw - 2))) >>> (cw - 1);
    max_v   = (64'sd1 <<< (iw - 1)) - 64'sd1;
    min_v   = -max_v - 64'sd1;
    if (rounded > max_v) begin
      return max_v;
    end
    if (rounded < min_v) begin
      return min_v;
    end
    return rounded;
  endfunction

endpackage

// File: rtl/audio_fir_mac.sv
// Registered signed multiplier followed by an accumulator.
//   clk, reset  : clock, asynchronous active-high reset
//   flush       : synchronous clear of product and accumulator
//   mul_en      : register sample*coeff this cycle
//   mul_first   : this product starts a new sum (accumulator is restarted from it)
//   sample      : signed multiplicand (IW bits)
//   coeff       : signed coefficient (CW bits)
//   acc_valid   : a registered product is being folded into the accumulator this cycle
//   acc_next    : accumulator value loaded at the coming edge when acc_valid is high
module audio_fir_mac #(
  parameter int unsigned IW = 16,
  parameter int unsigned CW = 16,
  parameter int unsigned AW = 37
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 mul_en,
  input  logic                 mul_first,
  input  logic signed [IW-1:0] sample,
  input  logic signed [CW-1:0] coeff,
  output logic                 acc_valid,
  output logic signed [AW-1:0] acc_next
);

  localparam int unsigned PW = IW + CW;

  logic signed [PW-1:0] prod_q;
  logic                 prod_vld_q;
  logic                 prod_first_q;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_base;
  logic signed [AW-1:0] prod_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q       <= '0;
      prod_vld_q   <= 1'b0;
      prod_first_q <= 1'b0;
      acc_q        <= '0;
    end else if (flush) begin
      prod_q       <= '0;
      prod_vld_q   <= 1'b0;
      prod_first_q <= 1'b0;
      acc_q        <= '0;
    end else begin
      prod_vld_q <= mul_en;
      if (mul_en) begin
        prod_q       <= PW'(sample) * PW'(coeff);
        prod_first_q <= mul_first;
      end
      if (prod_vld_q) begin
        acc_q <= acc_next;
      end
    end
  end

  always_comb begin
    acc_base = prod_first_q ? '0 : acc_q;
    prod_ext = AW'(prod_q);
    acc_next = acc_base + prod_ext;
  end

  assign acc_valid = prod_vld_q;

endmodule

// File: rtl/audio_fir_decimator.sv
// Multi-channel time-multiplexed decimating FIR with one shared multiplier.
//   clk, reset : clock, asynchronous active-high reset
//   flush      : synchronous clear of delay lines, phase and any in-flight computation
//   coeffs     : TAPS signed Q1.(CW-1) coefficients, shared by all channels
//   in_data    : packed input frame, channel 0 in the LSBs; in_valid/in_ready handshake
//   out_data   : packed filtered frame; out_valid/out_ready handshake, held until taken
//   busy       : a filter computation is in progress
// Every DECIM-th accepted frame starts CHANNELS*TAPS multiply cycles (channel-major, tap
// ascending), one drain cycle for the product register and one cycle to publish all channels.
module audio_fir_decimator
  import audio_fir_pkg::*;
#(
  parameter int unsigned IW       = 16,
  parameter int unsigned CW       = 16,
  parameter int unsigned TAPS     = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DECIM    = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic signed [CW-1:0]     coeffs [TAPS],
  input  logic [CHANNELS*IW-1:0]   in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [CHANNELS*IW-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int unsigned AW   = acc_width(IW, CW, TAPS);
  localparam int unsigned TapW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PhW  = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [TapW-1:0] TapLast = TapW'(TAPS - 1);
  localparam logic [ChW-1:0]  ChLast  = ChW'(CHANNELS - 1);
  localparam logic [PhW-1:0]  PhLast  = PhW'(DECIM - 1);

  fir_state_e state_q, state_d;

  logic signed [IW-1:0]   dline_q [CHANNELS][TAPS];
  logic [PhW-1:0]         phase_q;
  logic [TapW-1:0]        tap_q;
  logic [ChW-1:0]         ch_q;
  logic                   mac_last_q;
  logic [ChW-1:0]         mac_ch_q;
  logic signed [IW-1:0]   stage_q [CHANNELS];
  logic [CHANNELS*IW-1:0] out_data_q;
  logic                   out_valid_q;

  logic                 accept;
  logic                 trigger;
  logic                 mac_done;
  logic                 mul_en;
  logic signed [IW-1:0] mul_sample;
  logic signed [CW-1:0] mul_coeff;
  logic                 acc_valid;
  logic signed [AW-1:0] acc_next;

  // A pending, unaccepted output frame blocks new input so it can never be overwritten.
  assign in_ready = (state_q == StIdle) && !(out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign trigger  = accept && (phase_q == PhLast);
  assign mac_done = (ch_q == ChLast) && (tap_q == TapLast);
  assign mul_en   = (state_q == StMac);

  assign busy      = (state_q != StIdle);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  // FSM

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (trigger) state_d = StMac;
        StMac:   if (mac_done) state_d = StDrain;
        StDrain: state_d = StRound;
        StRound: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Delay lines and decimation phase

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          dline_q[c][k] <= '0;
        end
      end
      phase_q <= '0;
    end else if (flush) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          dline_q[c][k] <= '0;
        end
      end
      phase_q <= '0;
    end else if (accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = TAPS - 1; k > 0; k--) begin
          dline_q[c][k] <= dline_q[c][k-1];
        end
        dline_q[c][0] <= in_data[c*IW +: IW];
      end
      phase_q <= (phase_q == PhLast) ? '0 : phase_q + PhW'(1);
    end
  end

  // Tap / channel sequencing during MAC

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap_q <= '0;
      ch_q  <= '0;
    end else if (flush || (state_q != StMac)) begin
      tap_q <= '0;
      ch_q  <= '0;
    end else if (tap_q == TapLast) begin
      tap_q <= '0;
      ch_q  <= ch_q + ChW'(1);
    end else begin
      tap_q <= tap_q + TapW'(1);
    end
  end

  assign mul_sample = dline_q[ch_q][tap_q];
  assign mul_coeff  = coeffs[tap_q];

  // Tag travelling with the registered product: marks the final tap of a channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mac_last_q <= 1'b0;
      mac_ch_q   <= '0;
    end else if (flush) begin
      mac_last_q <= 1'b0;
      mac_ch_q   <= '0;
    end else if (mul_en) begin
      mac_last_q <= (tap_q == TapLast);
      mac_ch_q   <= ch_q;
    end
  end

  audio_fir_mac #(
    .IW (IW),
    .CW (CW),
    .AW (AW)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .mul_en    (mul_en),
    .mul_first (tap_q == '0),
    .sample    (mul_sample),
    .coeff     (mul_coeff),
    .acc_valid (acc_valid),
    .acc_next  (acc_next)
  );

  // Per-channel results are staged and only published together in StRound.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        stage_q[c] <= '0;
      end
    end else if (!flush && acc_valid && mac_last_q) begin
      stage_q[mac_ch_q] <= IW'(round_sat({{(64 - AW){acc_next[AW-1]}}, acc_next}, AW, IW, CW));
    end
  end

  // Output register and handshake

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (state_q == StRound) begin
      for (int c = 0; c < CHANNELS; c++) begin
        out_data_q[c*IW +: IW] <= stage_q[c];
      end
      out_valid_q <= 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_fir_decimator.sv
// Self-checking bench for audio_fir_decimator (defaults: 2 channels, 32 taps, DECIM 6).
// A frame-level reference (sample history, dot product, round, clamp, fixed 66-edge latency)
// is checked against the DUT every cycle, plus literal expectations for directed cases.
module tb_audio_fir_decimator;

  localparam int Taps    = 32;
  localparam int Decim   = 6;
  localparam int Latency = 2 * Taps + 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               flush;
  logic signed [15:0] coeffs [Taps];
  logic [31:0]        in_data;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  audio_fir_decimator dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .coeffs    (coeffs),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference state
  int          hist [2][Taps];
  int          phase;
  int          remaining;
  int          trig_cyc;
  bit          exp_valid;
  bit          exp_rdy;
  int          exp_data [2];
  int          pend [2];
  bit          prev_valid;
  logic [31:0] rcv [$];
  bit          rnd_done;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int slice(input logic [31:0] f, input int c);
    logic signed [15:0] s;
    s = f[c*16 +: 16];
    return int'(s);
  endfunction

  function automatic int model_out(input int c);
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < Taps; k++) acc += longint'(hist[c][k]) * longint'(coeffs[k]);
    r = (acc + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) for (int k = 0; k < Taps; k++) hist[c][k] = 0;
    phase     = 0;
    remaining = 0;
    exp_valid = 1'b0;
  endtask

  // Compare point: 2 time units after the falling edge, inputs for the next edge are settled.
  initial begin
    model_clear();
    exp_data   = '{0, 0};
    prev_valid = 1'b0;
    trig_cyc   = -1000;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        model_clear();
        exp_data = '{0, 0};
      end
      exp_rdy = (remaining == 0) && !(exp_valid && !out_ready);
      chk("out_valid", int'(out_valid), int'(exp_valid));
      chk("busy", int'(busy), int'(remaining != 0));
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      chk("out_data_ch0", slice(out_data, 0), exp_data[0]);
      chk("out_data_ch1", slice(out_data, 1), exp_data[1]);
      if (out_valid && !prev_valid) chk("latency", cyc - trig_cyc, Latency);
      prev_valid = out_valid;
      if (!reset) begin
        if (flush) begin
          model_clear();
        end else begin
          if (out_valid && out_ready) rcv.push_back(out_data);
          if (exp_valid && out_ready) exp_valid = 1'b0;
          if (remaining > 0) begin
            remaining--;
            if (remaining == 0) begin
              exp_valid = 1'b1;
              exp_data  = pend;
            end
          end
          if (in_valid && exp_rdy) begin
            for (int c = 0; c < 2; c++) begin
              for (int k = Taps - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
              hist[c][0] = slice(in_data, c);
            end
            if (phase == Decim - 1) begin
              pend[0]   = model_out(0);
              pend[1]   = model_out(1);
              remaining = Latency;
              trig_cyc  = cyc + 1;
            end
            phase = (phase + 1) % Decim;
          end
        end
      end
    end
  end

  // Stimulus helpers: every task starts and ends 1 time unit after a falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [31:0] d);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 300 && !ok; t++) begin
      #2;
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout at cycle %0d: in_ready never rose, required 1", cyc);
    end
  endtask

  task automatic prep();
    out_ready = 1'b1;
    idle(80);
    flush = 1'b1;
    step();
    flush = 1'b0;
    rcv.delete();
  endtask

  task automatic rand_coeffs();
    for (int k = 0; k < Taps; k++) coeffs[k] = 16'($urandom_range(0, 16'hFFFF));
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    rnd_done  = 1'b0;
    for (int k = 0; k < Taps; k++) coeffs[k] = '0;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;

    // Impulse response through the decimator: outputs sample taps 5, 11, 17, 23, 29.
    prep();
    for (int k = 0; k < Taps; k++) coeffs[k] = 16'(k * 100);
    send(32'h0000_7FFF);
    repeat (35) send(32'h0);
    idle(80);
    chk("imp_count", rcv.size(), 6);
    chk("imp_k5", slice(rcv[0], 0), 500);
    chk("imp_k11", slice(rcv[1], 0), 1100);
    chk("imp_k17", slice(rcv[2], 0), 1700);
    chk("imp_k23", slice(rcv[3], 0), 2300);
    chk("imp_k29", slice(rcv[4], 0), 2900);
    chk("imp_past_end", slice(rcv[5], 0), 0);
    chk("imp_ch1", slice(rcv[0], 1), 0);

    // Unity DC gain once the line is full.
    prep();
    for (int k = 0; k < Taps; k++) coeffs[k] = 16'sd1024;
    repeat (48) send({16'd1000, 16'd1000});
    idle(80);
    chk("dc_count", rcv.size(), 8);
    chk("dc_ch0", slice(rcv[7], 0), 1000);
    chk("dc_ch1", slice(rcv[7], 1), 1000);

    // Decimation of a ramp: 60 frames -> 10 outputs.
    prep();
    rand_coeffs();
    for (int i = 1; i <= 60; i++) send({16'(-i), 16'(i)});
    idle(80);
    chk("dec_count", rcv.size(), 10);

    // Saturation in both directions.
    prep();
    for (int k = 0; k < Taps; k++) coeffs[k] = 16'sh7FFF;
    repeat (6) send(32'h8000_7FFF);
    idle(80);
    chk("sat_pos", slice(rcv[0], 0), 32767);
    chk("sat_neg", slice(rcv[0], 1), -32768);

    // Round half up: +1.5 -> 2, -1.5 -> -1.
    prep();
    for (int k = 0; k < Taps; k++) coeffs[k] = '0;
    coeffs[0] = 16'sh4000;
    repeat (6) send(32'hFFFD_0003);
    idle(80);
    chk("round_pos", slice(rcv[0], 0), 2);
    chk("round_neg", slice(rcv[0], 1), -1);

    // Backpressure: first output held for a while, next frame must wait.
    prep();
    rand_coeffs();
    out_ready = 1'b0;
    repeat (6) send($urandom);
    fork
      send($urandom);
      begin
        repeat (100) step();
        out_ready = 1'b1;
      end
    join
    repeat (5) send($urandom);
    idle(80);
    chk("bp_count", rcv.size(), 2);

    // Flush ten cycles into MAC: nothing comes out, next result is from a clean start.
    prep();
    rand_coeffs();
    repeat (6) send($urandom);
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle(80);
    chk("flush_no_out", rcv.size(), 0);
    repeat (6) send($urandom);
    idle(80);
    chk("flush_after", rcv.size(), 1);

    // Asynchronous reset ten cycles into MAC.
    prep();
    repeat (6) send($urandom);
    repeat (10) step();
    reset = 1'b1;
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_data", int'(out_data), 0);
    step();
    step();
    reset = 1'b0;
    idle(80);
    chk("rst_no_out", rcv.size(), 0);
    repeat (6) send($urandom);
    idle(80);
    chk("rst_after", rcv.size(), 1);

    // Random traffic with random gaps and random downstream stalls.
    prep();
    rand_coeffs();
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          send($urandom);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
      end
    join
    out_ready = 1'b1;
    idle(100);
    chk("rnd_count", rcv.size(), 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
